// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;

  localparam int PIPE_DATA_W_DEF = 32;
  localparam int PIPE_CNT_W_DEF  = 16;

  // Payload bundle widths used by the IF/ID .. MEM/WB instances.
  localparam int OPCODE_W = 5;
  localparam int RD_W     = 9;
  localparam int WORD_W   = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and optional skid buffer.
// Define PIPE_PERF_EN to build the stall/bubble/flush performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_t       state_q;
  logic [DATA_W-1:0] main_q;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;
    pipe_state_t       state_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = PS_EMPTY;
      end else begin
        case (state_q)
          PS_EMPTY: if (in_xfer) state_d = PS_ONE;
          PS_ONE: begin
            if (in_xfer && !out_xfer)      state_d = PS_TWO;
            else if (!in_xfer && out_xfer) state_d = PS_EMPTY;
          end
          PS_TWO:   if (out_xfer) state_d = PS_ONE;
          default:  state_d = PS_EMPTY;
        endcase
      end
    end

    // NOTE: payload registers are reset because out_data must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= PS_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        // Registered ready: decided from the next state, never from out_ready directly.
        ready_q <= (state_d != PS_TWO);
        case (state_q)
          PS_EMPTY: if (in_xfer) main_q <= in_data;
          PS_ONE: begin
            if (in_xfer && out_xfer) main_q <= in_data;
            else if (in_xfer)        skid_q <= in_data;
          end
          PS_TWO:   if (out_xfer) main_q <= skid_q;
          default:  ;
        endcase
      end
    end

    assign in_ready = ready_q;

  end else begin : g_noskid

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= PS_EMPTY;
        main_q  <= '0;
      end else if (flush) begin
        state_q <= PS_EMPTY;
      end else if (in_xfer) begin
        state_q <= PS_ONE;
        main_q  <= in_data;
      end else if (out_xfer) begin
        state_q <= PS_EMPTY;
      end
    end

    assign in_ready = !out_valid | out_ready;

  end

`ifdef PIPE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid),
    .clear (1'b0),
    .cnt   (bubble_cnt)
  );

  // A flush only counts when it actually killed something held.
  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush & out_valid),
    .clear (1'b0),
    .cnt   (flush_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline register replacing the fixed per-boundary registers between IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds per-stage valid/ready handshake, a flush that kills in-flight instructions on a taken branch, and an optional skid buffer that breaks the ready path.
- One instance is placed per stage boundary. Payload width is set per instance, so one module covers opcode, register-index, operand and result bundles.

Parameters:
- DATA_W, 32: payload width in bits, 1..256.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the performance counters (used only with PIPE_PERF_EN).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries this cycle.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  this stage accepts a payload.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to downstream.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_PERF_EN only).
- bubble_cnt  out  CNT_W  cycles with out_valid=0 (PIPE_PERF_EN only).
- flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry (PIPE_PERF_EN only).

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, in_ready=1, state EMPTY, skid entry cleared, counters 0. Applies immediately, including mid-transfer; any held payloads are lost.
- Transfer rules:
  - Input transfer occurs when in_valid&in_ready at the clock edge.
  - Output transfer occurs when out_valid&out_ready at the clock edge.
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
  - Order is strict FIFO; no payload is duplicated or dropped except by flush.
- SKID=1 state machine. States are EMPTY (0 held), ONE (main reg valid), TWO (main and skid valid).
  - EMPTY: input transfer -> ONE.
  - ONE:
    - input and output transfer -> ONE, main takes new data.
    - input transfer only -> TWO, new data goes to skid.
    - output transfer only -> EMPTY.
  - TWO:
    - output transfer -> ONE, skid moves to main.
    - no input is accepted in TWO.
  - in_ready is registered: in_ready = (next_state != TWO). It has no combinational path from out_ready.
  - out_valid = (state != EMPTY). out_data = main reg.
- SKID=0:
  - Single register. in_ready = !out_valid | out_ready (combinational).
  - Full throughput with no skid.
- Flush:
  - flush=1 at an edge -> state EMPTY, out_valid=0, in_ready=1 on the next cycle.
  - A simultaneous input transfer is discarded (flush wins).
  - A simultaneous output transfer still completes downstream.
  - Data registers need not be cleared; out_data is don't-care while out_valid=0.
- Back-pressure: out_valid and out_data stay stable while out_valid&!out_ready (no mid-stall change).
- Throughput: sustained one transfer per cycle when out_ready=1 continuously, for both SKID values.

Optional Feature:
- Macro PIPE_PERF_EN.
- Defined:
  - stall_cnt, bubble_cnt and flush_cnt count as described under Ports.
  - Counters saturate at 2^CNT_W-1 (no wrap).
  - flush_cnt increments only when flush=1 and state != EMPTY.
  - All counters reset to 0 on rst.
- Undefined:
  - Counter ports are still present but tied to 0.
  - No counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;
  - constants PIPE_DATA_W_DEF=32 and PIPE_CNT_W_DEF=16;
  - the stage payload bundle widths: OPCODE_W=5, RD_W=9, WORD_W=32.
- One sub-module, pipe_sat_counter (CNT_W, inc, clear, async rst), instantiated three times under PIPE_PERF_EN.

Test Plan:
- Reset mid-stream: SKID=1, load 0xA5A5A5A5 and 0x0000_0001 with out_ready=0 (state TWO), assert rst asynchronously -> out_valid=0, out_data=0 and in_ready=1 immediately, before the next edge.
- Streaming: SKID=1, out_ready=1, push 0x1..0x10 on consecutive cycles -> 0x1..0x10 emerge in order, one per cycle, starting 1 cycle after the first accept.
- Back-pressure: push 0x11, 0x22, 0x33 with out_ready=0 -> 0x11 and 0x22 held, in_ready=0 after the second accept, 0x33 held off. Raise out_ready -> 0x11, 0x22, 0x33 in order, with no loss or duplicate.
- Flush collision: state ONE holding 0x44, flush=1 with in_valid=1 carrying 0x55 -> next cycle out_valid=0, in_ready=1, and 0x55 never appears.
- SKID=0 comparison: same stimulus as the back-pressure test -> in_ready follows out_ready in the same cycle, and output order is identical.
- PIPE_PERF_EN: 3 stall cycles, 4 bubble cycles and 1 flush of a valid entry -> stall_cnt=3, bubble_cnt=4, flush_cnt=1. With CNT_W=2 and 5 stall cycles -> stall_cnt=3 (saturated).
